// File: rtl/urv_irq_ctrl_pkg.sv
// Shared constants for the uRV trap controller: CSR ids, mip/mstatus bit positions,
// cause codes and the request-index to cause mapping used by the priority encoder.
package urv_irq_ctrl_pkg;

    localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ID_MIE     = 12'h304;
    localparam logic [11:0] CSR_ID_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ID_MIP     = 12'h344;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIP_TIMER_BIT    = 7;
    localparam int unsigned MIP_IRQ_BASE     = 16;

    // Sync sources occupy request indices 0..3, the timer index 4, external lines 5+k.
    localparam int unsigned N_SYNC    = 4;
    localparam int unsigned REQ_TIMER = N_SYNC;
    localparam int unsigned REQ_IRQ0  = N_SYNC + 1;

    localparam logic [31:0] CAUSE_IRQ_FLAG       = 32'h8000_0000;
    localparam logic [31:0] CAUSE_ILLEGAL_INSN   = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT     = 32'd3;
    localparam logic [31:0] CAUSE_UNALIGNED_LOAD = 32'd4;
    localparam logic [31:0] CAUSE_UNALIGNED_STORE = 32'd6;
    localparam logic [31:0] CAUSE_TIMER          = 32'h8000_0007;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HANDLER
    } irq_state_e;

    function automatic logic [31:0] cause_of(input int unsigned idx);
        case (idx)
            0:       return CAUSE_ILLEGAL_INSN;
            1:       return CAUSE_BREAKPOINT;
            2:       return CAUSE_UNALIGNED_LOAD;
            3:       return CAUSE_UNALIGNED_STORE;
            4:       return CAUSE_TIMER;
            default: return CAUSE_IRQ_FLAG | 32'(MIP_IRQ_BASE + idx - REQ_IRQ0);
        endcase
    endfunction

endpackage

// File: rtl/urv_irq_prio_enc.sv
// Fixed-priority cause encoder: lowest set request index wins.
module urv_irq_prio_enc
    import urv_irq_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ = 4
) (
    input  logic [N_IRQ+4:0] req,
    output logic             valid_c,
    output logic [31:0]      cause_c
);

    always_comb begin
        valid_c = 1'b0;
        cause_c = '0;
        for (int unsigned i = 0; i < N_IRQ + 5; i++) begin
            if (!valid_c && req[i]) begin
                valid_c = 1'b1;
                cause_c = cause_of(i);
            end
        end
    end

endmodule

// File: rtl/urv_irq_ctrl.sv
// uRV exception/interrupt controller: pending tracking, mstatus stacking, CSRs
// and the request/acknowledge/eret handshake with the execute stage.
module urv_irq_ctrl
    import urv_irq_ctrl_pkg::*;
#(
    parameter int unsigned     N_IRQ        = 4,
    parameter logic [N_IRQ-1:0] IRQ_EDGE    = '0,
    parameter bit              VECTORED     = 1'b1,
    parameter logic [31:0]     RESET_VECTOR = 32'h8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             x_stall_i,
    input  logic             x_kill_i,
    input  logic             d_is_csr_i,
    input  logic             d_is_eret_i,
    input  logic [11:0]      d_csr_sel_i,
    input  logic [31:0]      x_csr_write_value_i,
    input  logic [N_IRQ-1:0] exp_irq_i,
    input  logic             exp_tick_i,
    input  logic             exp_breakpoint_i,
    input  logic             exp_unaligned_load_i,
    input  logic             exp_unaligned_store_i,
    input  logic             exp_invalid_insn_i,
    input  logic [31:0]      x_exception_pc_i,
    input  logic             x_exception_taken_i,
    output logic             x_exception_o,
    output logic [31:0]      x_exception_pc_o,
    output logic [31:0]      x_exception_vector_o,
    output logic [31:0]      csr_mstatus_o,
    output logic [31:0]      csr_mip_o,
    output logic [31:0]      csr_mie_o,
    output logic [31:0]      csr_mepc_o,
    output logic [31:0]      csr_mcause_o,
    output logic [31:0]      csr_mtvec_o
);

    localparam int unsigned N_REQ    = N_IRQ + 5;
    localparam logic [31:0] MIE_MASK = (((32'd1 << N_IRQ) - 32'd1) << MIP_IRQ_BASE)
                                       | (32'd1 << MIP_TIMER_BIT);

    irq_state_e        state_q, state_d;
    logic              exc_q, exc_d;
    logic [31:0]       cause_q;
    logic [31:0]       mepc_q, mcause_q, mie_q, mtvec_q;
    logic              mst_mie_q, mst_mpie_q;
    logic [N_SYNC-1:0] sync_q, sync_d, sync_set;
    logic              timer_q, timer_d;
    logic [N_IRQ-1:0]  irq_prev_q, irq_pend_q, irq_pend_d;
    logic [N_REQ-1:0]  req_c;
    logic              enc_valid_c;
    logic [31:0]       enc_cause_c;
    logic              upd_c, take_c, eret_c;
    logic              wr_mstatus_c, wr_mie_c, wr_mtvec_c, wr_mepc_c, wr_mip_c;

    assign upd_c        = !x_stall_i && !x_kill_i;
    assign wr_mstatus_c = upd_c && d_is_csr_i && (d_csr_sel_i == CSR_ID_MSTATUS);
    assign wr_mie_c     = upd_c && d_is_csr_i && (d_csr_sel_i == CSR_ID_MIE);
    assign wr_mtvec_c   = upd_c && d_is_csr_i && (d_csr_sel_i == CSR_ID_MTVEC);
    assign wr_mepc_c    = upd_c && d_is_csr_i && (d_csr_sel_i == CSR_ID_MEPC);
    assign wr_mip_c     = upd_c && d_is_csr_i && (d_csr_sel_i == CSR_ID_MIP);
    assign take_c       = (state_q == S_REQ) && x_exception_taken_i && !x_stall_i;
    assign eret_c       = (state_q == S_HANDLER) && upd_c && d_is_eret_i;

    assign sync_set = {exp_unaligned_store_i, exp_unaligned_load_i,
                       exp_breakpoint_i, exp_invalid_insn_i};

    // Pending updates: a set in the same cycle as a clear always wins.
    always_comb begin
        sync_d     = sync_q;
        timer_d    = timer_q;
        irq_pend_d = irq_pend_q;
        for (int unsigned i = 0; i < N_SYNC; i++) begin
            if (sync_set[i])
                sync_d[i] = 1'b1;
            else if (take_c && (cause_q == cause_of(i)))
                sync_d[i] = 1'b0;
        end
        if (exp_tick_i)
            timer_d = 1'b1;
        else if ((take_c && (cause_q == CAUSE_TIMER))
                 || (wr_mip_c && !x_csr_write_value_i[MIP_TIMER_BIT]))
            timer_d = 1'b0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            if (!IRQ_EDGE[k])
                irq_pend_d[k] = exp_irq_i[k];
            else if (exp_irq_i[k] && !irq_prev_q[k])
                irq_pend_d[k] = 1'b1;
            else if ((take_c && (cause_q == cause_of(REQ_IRQ0 + k)))
                     || (wr_mip_c && !x_csr_write_value_i[MIP_IRQ_BASE + k]))
                irq_pend_d[k] = 1'b0;
        end
    end

    assign req_c = {irq_pend_q & mie_q[MIP_IRQ_BASE +: N_IRQ] & {N_IRQ{mst_mie_q}},
                    timer_q & mie_q[MIP_TIMER_BIT] & mst_mie_q,
                    sync_q[3:1],
                    sync_q[0] | exp_invalid_insn_i};

    urv_irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio_enc (
        .req     (req_c),
        .valid_c (enc_valid_c),
        .cause_c (enc_cause_c)
    );

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        case (state_q)
            S_IDLE: begin
                if (enc_valid_c) begin
                    state_d = S_REQ;
                    exc_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (take_c) begin
                    state_d = S_HANDLER;
                    exc_d   = 1'b0;
                end else if (!enc_valid_c) begin
                    state_d = S_IDLE;
                    exc_d   = 1'b0;
                end
            end
            S_HANDLER: begin
                if (eret_c)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                exc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cause_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mie_q      <= '0;
            mtvec_q    <= RESET_VECTOR;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            sync_q     <= '0;
            timer_q    <= 1'b0;
            irq_prev_q <= '0;
            irq_pend_q <= '0;
        end else begin
            sync_q     <= sync_d;
            timer_q    <= timer_d;
            irq_prev_q <= exp_irq_i;
            irq_pend_q <= irq_pend_d;

            if (enc_valid_c && ((state_q == S_IDLE) || ((state_q == S_REQ) && !take_c)))
                cause_q <= enc_cause_c;

            // Trap entry overrides a coincident mstatus write.
            if (take_c) begin
                mst_mpie_q <= mst_mie_q;
                mst_mie_q  <= 1'b0;
            end else if (eret_c) begin
                mst_mie_q  <= mst_mpie_q;
                mst_mpie_q <= 1'b1;
            end else if (wr_mstatus_c) begin
                mst_mie_q  <= x_csr_write_value_i[MSTATUS_MIE_BIT];
                mst_mpie_q <= x_csr_write_value_i[MSTATUS_MPIE_BIT];
            end

            if (take_c) begin
                mepc_q   <= x_exception_pc_i;
                mcause_q <= cause_q;
            end else if (wr_mepc_c) begin
                mepc_q <= x_csr_write_value_i;
            end

            if (wr_mie_c)
                mie_q <= x_csr_write_value_i & MIE_MASK;
            if (wr_mtvec_c)
                mtvec_q <= {x_csr_write_value_i[31:2], 2'b00};
        end
    end

    assign x_exception_o        = exc_q;
    assign x_exception_pc_o     = mepc_q;
    assign x_exception_vector_o = mtvec_q + ((VECTORED && cause_q[31])
                                             ? {25'd0, cause_q[4:0], 2'b00} : 32'd0);
    assign csr_mstatus_o = (32'(mst_mpie_q) << MSTATUS_MPIE_BIT) | (32'(mst_mie_q) << MSTATUS_MIE_BIT);
    assign csr_mip_o     = (32'(irq_pend_q) << MIP_IRQ_BASE) | (32'(timer_q) << MIP_TIMER_BIT);
    assign csr_mie_o     = mie_q;
    assign csr_mepc_o    = mepc_q;
    assign csr_mcause_o  = mcause_q;
    assign csr_mtvec_o   = mtvec_q;

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// Bench for urv_irq_ctrl: directed trap scenarios plus randomized traffic checked
// against a trap-level reference model.
module tb_urv_irq_ctrl;

    localparam int unsigned N = 4;
    localparam logic [N-1:0] EDGE_MASK = 4'b0100;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         x_stall_i, x_kill_i, d_is_csr_i, d_is_eret_i;
    logic [11:0]  d_csr_sel_i;
    logic [31:0]  x_csr_write_value_i;
    logic [N-1:0] exp_irq_i;
    logic         exp_tick_i, exp_breakpoint_i, exp_unaligned_load_i;
    logic         exp_unaligned_store_i, exp_invalid_insn_i;
    logic [31:0]  x_exception_pc_i;
    logic         x_exception_taken_i;
    logic         x_exception_o;
    logic [31:0]  x_exception_pc_o, x_exception_vector_o;
    logic [31:0]  csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o, csr_mtvec_o;

    int n_checks = 0;
    int n_fail   = 0;

    urv_irq_ctrl #(
        .N_IRQ        (N),
        .IRQ_EDGE     (EDGE_MASK),
        .VECTORED     (1'b1),
        .RESET_VECTOR (32'h8)
    ) dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .x_stall_i             (x_stall_i),
        .x_kill_i              (x_kill_i),
        .d_is_csr_i            (d_is_csr_i),
        .d_is_eret_i           (d_is_eret_i),
        .d_csr_sel_i           (d_csr_sel_i),
        .x_csr_write_value_i   (x_csr_write_value_i),
        .exp_irq_i             (exp_irq_i),
        .exp_tick_i            (exp_tick_i),
        .exp_breakpoint_i      (exp_breakpoint_i),
        .exp_unaligned_load_i  (exp_unaligned_load_i),
        .exp_unaligned_store_i (exp_unaligned_store_i),
        .exp_invalid_insn_i    (exp_invalid_insn_i),
        .x_exception_pc_i      (x_exception_pc_i),
        .x_exception_taken_i   (x_exception_taken_i),
        .x_exception_o         (x_exception_o),
        .x_exception_pc_o      (x_exception_pc_o),
        .x_exception_vector_o  (x_exception_vector_o),
        .csr_mstatus_o         (csr_mstatus_o),
        .csr_mip_o             (csr_mip_o),
        .csr_mie_o             (csr_mie_o),
        .csr_mepc_o            (csr_mepc_o),
        .csr_mcause_o          (csr_mcause_o),
        .csr_mtvec_o           (csr_mtvec_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: architectural state plus "trap requested" / "in handler" flags.
    bit [3:0]    m_sync;
    bit          m_timer;
    bit [N-1:0]  m_pend, m_prev;
    logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_cause;
    bit          m_MIE, m_MPIE, m_req, m_hdl;

    function automatic logic [31:0] code_of(input int i);
        case (i)
            0:       return 32'd2;
            1:       return 32'd3;
            2:       return 32'd4;
            3:       return 32'd6;
            4:       return 32'h8000_0007;
            default: return 32'h8000_0010 + 32'(i - 5);
        endcase
    endfunction

    task automatic reset_model();
        m_sync = '0; m_timer = 0; m_pend = '0; m_prev = '0;
        m_mie = 0; m_mtvec = 32'h8; m_mepc = 0; m_mcause = 0; m_cause = 0;
        m_MIE = 0; m_MPIE = 0; m_req = 0; m_hdl = 0;
    endtask

    function automatic logic [31:0] m_vector();
        return m_mtvec + (m_cause[31] ? 32'(4 * (m_cause & 32'h1f)) : 32'd0);
    endfunction

    function automatic logic [31:0] m_mip();
        return (32'(m_pend) << 16) | (32'(m_timer) << 7);
    endfunction

    // Advance one clock: evaluate the model on the pre-edge inputs, then commit after the edge.
    task automatic step();
        bit upd, take, idle, have, eret, wr_mip;
        bit [N+4:0] act;
        logic [31:0] best, val;
        bit [3:0] n_sync; bit n_timer; bit [N-1:0] n_pend;
        bit n_req, n_hdl, n_MIE, n_MPIE;
        logic [31:0] n_cause, n_mepc, n_mcause, n_mie, n_mtvec;
        val  = x_csr_write_value_i;
        upd  = !x_stall_i && !x_kill_i;
        act[0] = m_sync[0] | exp_invalid_insn_i;
        act[3:1] = m_sync[3:1];
        act[4] = m_MIE & m_mie[7] & m_timer;
        for (int k = 0; k < N; k++) act[5+k] = m_MIE & m_mie[16+k] & m_pend[k];
        have = 0; best = 0;
        for (int i = 0; i < N + 5; i++)
            if (act[i] && !have) begin have = 1; best = code_of(i); end
        idle   = !m_req && !m_hdl;
        take   = m_req && x_exception_taken_i && !x_stall_i;
        eret   = m_hdl && upd && d_is_eret_i;
        wr_mip = upd && d_is_csr_i && d_csr_sel_i == 12'h344;
        n_req  = idle ? have : (m_req ? (!take && have) : 1'b0);
        n_hdl  = take ? 1'b1 : (eret ? 1'b0 : m_hdl);
        n_cause = ((idle || (m_req && !take)) && have) ? best : m_cause;
        n_sync = {exp_unaligned_store_i, exp_unaligned_load_i, exp_breakpoint_i, exp_invalid_insn_i};
        for (int i = 0; i < 4; i++)
            if (m_sync[i] && !(take && m_cause == code_of(i))) n_sync[i] = 1;
        n_timer = exp_tick_i || (m_timer && !(take && m_cause == 32'h8000_0007) && !(wr_mip && !val[7]));
        for (int k = 0; k < N; k++) begin
            if (!EDGE_MASK[k]) n_pend[k] = exp_irq_i[k];
            else n_pend[k] = (exp_irq_i[k] && !m_prev[k]) ||
                             (m_pend[k] && !(take && m_cause == code_of(5 + k)) && !(wr_mip && !val[16+k]));
        end
        n_MIE = m_MIE; n_MPIE = m_MPIE;
        if (take) begin n_MPIE = m_MIE; n_MIE = 0; end
        else if (eret) begin n_MIE = m_MPIE; n_MPIE = 1; end
        else if (upd && d_is_csr_i && d_csr_sel_i == 12'h300) begin n_MIE = val[3]; n_MPIE = val[7]; end
        n_mepc = take ? x_exception_pc_i : ((upd && d_is_csr_i && d_csr_sel_i == 12'h341) ? val : m_mepc);
        n_mcause = take ? m_cause : m_mcause;
        n_mie = (upd && d_is_csr_i && d_csr_sel_i == 12'h304) ? (val & 32'h000f_0080) : m_mie;
        n_mtvec = (upd && d_is_csr_i && d_csr_sel_i == 12'h305) ? (val & ~32'h3) : m_mtvec;
        @(posedge clk_i);
        #1;
        m_sync = n_sync; m_timer = n_timer; m_pend = n_pend; m_prev = exp_irq_i;
        m_req = n_req; m_hdl = n_hdl; m_cause = n_cause; m_MIE = n_MIE; m_MPIE = n_MPIE;
        m_mepc = n_mepc; m_mcause = n_mcause; m_mie = n_mie; m_mtvec = n_mtvec;
    endtask

    task automatic idle_inputs();
        x_stall_i = 0; x_kill_i = 0; d_is_csr_i = 0; d_is_eret_i = 0;
        d_csr_sel_i = '0; x_csr_write_value_i = '0; exp_irq_i = '0; exp_tick_i = 0;
        exp_breakpoint_i = 0; exp_unaligned_load_i = 0; exp_unaligned_store_i = 0;
        exp_invalid_insn_i = 0; x_exception_pc_i = '0; x_exception_taken_i = 0;
    endtask

    task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
        d_is_csr_i = 1; d_csr_sel_i = sel; x_csr_write_value_i = val;
        step();
        d_is_csr_i = 0; d_csr_sel_i = '0; x_csr_write_value_i = '0;
    endtask

    task automatic take(input logic [31:0] pc);
        x_exception_taken_i = 1; x_exception_pc_i = pc;
        step();
        x_exception_taken_i = 0; x_exception_pc_i = '0;
    endtask

    task automatic eret();
        d_is_eret_i = 1;
        step();
        d_is_eret_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n_i = 0;
        reset_model();
        #23 rst_n_i = 1;
        @(posedge clk_i); #1;
        n_checks++;
        if (x_exception_o !== 1'b0 || csr_mtvec_o !== 32'h8 || csr_mstatus_o !== 32'h0 ||
            csr_mepc_o !== 32'h0 || csr_mcause_o !== 32'h0 || csr_mie_o !== 32'h0 || csr_mip_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: exc=%b mtvec=%h mstatus=%h mepc=%h mcause=%h mie=%h mip=%h, required 0/8/0/0/0/0/0",
                     x_exception_o, csr_mtvec_o, csr_mstatus_o, csr_mepc_o, csr_mcause_o, csr_mie_o, csr_mip_o);
        end
    endtask

    task automatic test_illegal();
        exp_invalid_insn_i = 1;
        step();
        exp_invalid_insn_i = 0;
        n_checks++;
        if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL illegal_req_latency: got %b required 1", x_exception_o); end
        step(); step();
        n_checks++;
        if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL illegal_req_held: got %b required 1", x_exception_o); end
        take(32'h100);
        n_checks++;
        if (x_exception_o !== 1'b0 || csr_mepc_o !== 32'h100 || csr_mcause_o !== 32'h2 ||
            x_exception_vector_o !== 32'h8 || csr_mstatus_o[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_take: exc=%b mepc=%h mcause=%h vec=%h mstatus=%h, required 0/100/2/8/MIE=0",
                     x_exception_o, csr_mepc_o, csr_mcause_o, x_exception_vector_o, csr_mstatus_o);
        end
        eret();
    endtask

    task automatic test_edge_irq();
        csr_write(12'h305, 32'h200);
        csr_write(12'h304, 32'h4_0000);
        csr_write(12'h300, 32'h8);
        exp_irq_i = 4'b0100;
        step();
        exp_irq_i = '0;
        n_checks++;
        if (x_exception_o !== 1'b0 || csr_mip_o[18] !== 1'b1) begin
            n_fail++; $display("FAIL edge_pending: exc=%b mip=%h, required 0 and mip[18]=1", x_exception_o, csr_mip_o);
        end
        step();
        n_checks++;
        if (x_exception_o !== 1'b1 || x_exception_vector_o !== 32'h248) begin
            n_fail++; $display("FAIL edge_req: exc=%b vec=%h, required 1/248", x_exception_o, x_exception_vector_o);
        end
        take(32'h300);
        n_checks++;
        if (csr_mcause_o !== 32'h8000_0012 || csr_mip_o[18] !== 1'b0 || csr_mstatus_o !== 32'h80) begin
            n_fail++; $display("FAIL edge_take: mcause=%h mip=%h mstatus=%h, required 80000012/bit18=0/80",
                               csr_mcause_o, csr_mip_o, csr_mstatus_o);
        end
        eret();
        n_checks++;
        if (csr_mstatus_o !== 32'h88) begin n_fail++; $display("FAIL edge_eret: mstatus=%h required 88", csr_mstatus_o); end
    endtask

    task automatic test_level_irq();
        csr_write(12'h304, 32'h2_0000);
        csr_write(12'h300, 32'h0);
        exp_irq_i = 4'b0010;
        step(); step(); step();
        n_checks++;
        if (x_exception_o !== 1'b0 || csr_mip_o[17] !== 1'b1) begin
            n_fail++; $display("FAIL level_masked: exc=%b mip=%h, required 0 and mip[17]=1", x_exception_o, csr_mip_o);
        end
        csr_write(12'h300, 32'h8);
        step();
        n_checks++;
        if (x_exception_o !== 1'b1) begin n_fail++; $display("FAIL level_req: exc=%b required 1", x_exception_o); end
        exp_irq_i = '0;
        step(); step();
        n_checks++;
        if (x_exception_o !== 1'b0 || csr_mip_o[17] !== 1'b0) begin
            n_fail++; $display("FAIL level_withdraw: exc=%b mip=%h, required 0", x_exception_o, csr_mip_o);
        end
    endtask

    task automatic test_bp_timer();
        csr_write(12'h304, 32'h80);
        exp_breakpoint_i = 1; exp_tick_i = 1;
        step();
        exp_breakpoint_i = 0; exp_tick_i = 0;
        step();
        take(32'h400);
        n_checks++;
        if (csr_mcause_o !== 32'h3 || csr_mstatus_o !== 32'h80) begin
            n_fail++; $display("FAIL bp_first: mcause=%h mstatus=%h, required 3/80", csr_mcause_o, csr_mstatus_o);
        end
        eret();
        n_checks++;
        if (csr_mstatus_o[3] !== 1'b1) begin n_fail++; $display("FAIL bp_eret_mie: mstatus=%h required MIE=1", csr_mstatus_o); end
        step();
        n_checks++;
        if (x_exception_o !== 1'b1 || x_exception_vector_o !== 32'h21c) begin
            n_fail++; $display("FAIL timer_req: exc=%b vec=%h, required 1/21c", x_exception_o, x_exception_vector_o);
        end
        take(32'h404);
        n_checks++;
        if (csr_mcause_o !== 32'h8000_0007 || csr_mip_o[7] !== 1'b0) begin
            n_fail++; $display("FAIL timer_take: mcause=%h mip=%h, required 80000007/bit7=0", csr_mcause_o, csr_mip_o);
        end
        eret();
        n_checks++;
        if (csr_mstatus_o[3] !== 1'b1) begin n_fail++; $display("FAIL timer_eret_mie: mstatus=%h required MIE=1", csr_mstatus_o); end
    endtask

    task automatic test_async_reset();
        exp_invalid_insn_i = 1;
        step();
        exp_invalid_insn_i = 0;
        #2 rst_n_i = 0;
        #1;
        n_checks++;
        if (x_exception_o !== 1'b0 || csr_mtvec_o !== 32'h8 || csr_mie_o !== 32'h0 || csr_mstatus_o !== 32'h0 ||
            csr_mepc_o !== 32'h0 || csr_mcause_o !== 32'h0 || csr_mip_o !== 32'h0 || x_exception_vector_o !== 32'h8) begin
            n_fail++;
            $display("FAIL async_reset: exc=%b mtvec=%h mie=%h mstatus=%h mepc=%h mcause=%h mip=%h vec=%h, required 0/8/0/0/0/0/0/8",
                     x_exception_o, csr_mtvec_o, csr_mie_o, csr_mstatus_o, csr_mepc_o, csr_mcause_o, csr_mip_o, x_exception_vector_o);
        end
        reset_model();
        #1 rst_n_i = 1;
    endtask

    task automatic test_stall_take();
        exp_invalid_insn_i = 1;
        step();
        exp_invalid_insn_i = 0;
        x_stall_i = 1; x_exception_taken_i = 1; x_exception_pc_i = 32'h111;
        step();
        n_checks++;
        if (x_exception_o !== 1'b1 || csr_mepc_o !== 32'h0) begin
            n_fail++; $display("FAIL stalled_take: exc=%b mepc=%h, required 1/0", x_exception_o, csr_mepc_o);
        end
        x_stall_i = 0; x_exception_pc_i = 32'h222;
        step();
        x_exception_taken_i = 0; x_exception_pc_i = '0;
        n_checks++;
        if (x_exception_o !== 1'b0 || csr_mepc_o !== 32'h222 || csr_mcause_o !== 32'h2) begin
            n_fail++; $display("FAIL unstalled_take: exc=%b mepc=%h mcause=%h, required 0/222/2",
                               x_exception_o, csr_mepc_o, csr_mcause_o);
        end
        eret();
    endtask

    task automatic test_random();
        logic [11:0] sels [5];
        sels[0] = 12'h300; sels[1] = 12'h304; sels[2] = 12'h305; sels[3] = 12'h341; sels[4] = 12'h344;
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            if ($urandom_range(3) == 0) exp_irq_i = m_prev ^ 4'(1 << $urandom_range(N - 1));
            else exp_irq_i = m_prev;
            exp_tick_i            = ($urandom_range(15) == 0);
            exp_breakpoint_i      = ($urandom_range(31) == 0);
            exp_unaligned_load_i  = ($urandom_range(31) == 0);
            exp_unaligned_store_i = ($urandom_range(31) == 0);
            exp_invalid_insn_i    = ($urandom_range(47) == 0);
            x_stall_i           = ($urandom_range(3) == 0);
            x_kill_i            = ($urandom_range(7) == 0);
            x_exception_taken_i = ($urandom_range(1) == 0);
            x_exception_pc_i    = $urandom;
            if ($urandom_range(5) == 0) begin
                d_is_csr_i = 1;
                d_csr_sel_i = sels[$urandom_range(4)];
                x_csr_write_value_i = $urandom;
                if (d_csr_sel_i == 12'h300 && $urandom_range(3) != 0) x_csr_write_value_i[3] = 1'b1;
            end else begin
                d_is_eret_i = ($urandom_range(2) == 0);
            end
            step();
            n_checks++;
            if (x_exception_o !== m_req) begin
                n_fail++; $display("FAIL rnd_req cycle %0d: got %b required %b", c, x_exception_o, m_req);
            end
            n_checks++;
            if (csr_mepc_o !== m_mepc || x_exception_pc_o !== m_mepc || csr_mcause_o !== m_mcause) begin
                n_fail++; $display("FAIL rnd_mepc_mcause cycle %0d: mepc=%h pc_o=%h mcause=%h required %h/%h/%h",
                                   c, csr_mepc_o, x_exception_pc_o, csr_mcause_o, m_mepc, m_mepc, m_mcause);
            end
            n_checks++;
            if (csr_mstatus_o !== ((32'(m_MPIE) << 7) | (32'(m_MIE) << 3)) || csr_mie_o !== m_mie || csr_mtvec_o !== m_mtvec) begin
                n_fail++; $display("FAIL rnd_csr cycle %0d: mstatus=%h mie=%h mtvec=%h required MIE=%b MPIE=%b %h %h",
                                   c, csr_mstatus_o, csr_mie_o, csr_mtvec_o, m_MIE, m_MPIE, m_mie, m_mtvec);
            end
            n_checks++;
            if (csr_mip_o !== m_mip()) begin
                n_fail++; $display("FAIL rnd_mip cycle %0d: got %h required %h", c, csr_mip_o, m_mip());
            end
            if (m_req) begin
                n_checks++;
                if (x_exception_vector_o !== m_vector()) begin
                    n_fail++; $display("FAIL rnd_vector cycle %0d: got %h required %h", c, x_exception_vector_o, m_vector());
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_edge_irq();
        test_level_irq();
        test_bp_timer();
        test_async_reset();
        test_stall_take();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/urv_irq_ctrl.md
Name: urv_irq_ctrl

Overview:
Parametrised exception/interrupt controller for the uRV core.
- Supports N_IRQ external interrupt lines, each configurable as level- or edge-triggered.
- Keeps the synchronous exceptions (illegal insn, breakpoint, unaligned load/store) and the timer tick.
- Adds MIE/MPIE stacking on trap entry/exit, a writable mtvec, optional vectored dispatch and a fixed-priority cause encoder.
- Sits beside the execute stage: it requests a trap, the pipeline acknowledges it, and eret restores state.

Parameters:
N_IRQ, 4, number of external IRQ lines (1..16); line k appears at mip/mie bit 16+k.
IRQ_EDGE, 0, N_IRQ-bit mask; bit k=1 makes line k rising-edge-triggered, 0 makes it level.
VECTORED, 1, 1: interrupts jump to mtvec+4*code; 0: all traps jump to mtvec.
RESET_VECTOR, 32'h8, reset value of mtvec.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
x_stall_i  in  1  execute stall; blocks CSR/eret/take updates
x_kill_i  in  1  execute kill; blocks CSR/eret updates
d_is_csr_i  in  1  CSR write in execute
d_is_eret_i  in  1  eret in execute
d_csr_sel_i  in  12  CSR address
x_csr_write_value_i  in  32  CSR write data
exp_irq_i  in  N_IRQ  external interrupt lines (synchronous to clk_i)
exp_tick_i  in  1  timer tick pulse
exp_breakpoint_i, exp_unaligned_load_i, exp_unaligned_store_i, exp_invalid_insn_i  in  1 each  synchronous exception pulses
x_exception_pc_i  in  32  PC of the trapping instruction
x_exception_taken_i  in  1  pipeline acknowledges the trap
x_exception_o  out  1  trap request
x_exception_pc_o  out  32  mepc
x_exception_vector_o  out  32  trap target address
csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o, csr_mtvec_o  out  32 each  CSR read values

Behaviour:
- Reset (async on rst_n_i low): state=IDLE, x_exception_o=0, mepc=0, mcause=0, mie=0, MIE=MPIE=0, all pendings=0, mtvec=RESET_VECTOR.
- "Update" means a cycle with !x_stall_i && !x_kill_i. CSR writes and eret act only on update.
- mstatus: bit3=MIE, bit7=MPIE; all other bits read 0.
- mie: only bits 7 and 16..16+N_IRQ-1 are writable; others read 0.
- mtvec: bits[1:0] forced to 0.
- Sync exceptions:
  - Latched into sync_pend[3:0] in any cycle the pulse is high.
  - exp_invalid_insn_i also feeds the request combinationally.
  - Cleared only when taken.
- Timer: exp_tick_i sets mip[7].
- Level line k: mip[16+k] is a one-cycle registered copy of exp_irq_i[k]. Writes to it are ignored.
- Edge line k: rising edge (registered previous value) sets mip[16+k].
- Timer and edge pendings clear when taken, or on an mip write with that bit=0.
- If a set and a clear coincide, the set wins.
- Priority (highest first), code; interrupts have mcause[31]=1:
  - illegal 2
  - breakpoint 3
  - unaligned load 4
  - unaligned store 6
  - timer 7
  - irq0..irqN-1 as 16+k (lower k wins)
- Interrupt eligible = MIE & mip[b] & mie[b]. Sync exceptions ignore MIE/mie.
- FSM IDLE:
  - Enters REQ when any sync source or eligible interrupt exists.
  - x_exception_o goes high on the next clock: sync source in cycle n gives request at n+1; raw irq line at n gives request at n+2.
- FSM REQ:
  - x_exception_o=1; cause_q re-evaluated every cycle.
  - x_exception_taken_i && !x_stall_i: mepc<=x_exception_pc_i, mcause<=cause_q, MPIE<=MIE, MIE<=0, clear the taken pending, go to HANDLER, x_exception_o<=0.
  - If every source vanishes before ack (level line dropped, MIE cleared), return to IDLE and drop x_exception_o.
  - A take coinciding with an mstatus write: the take's MIE/MPIE update wins.
- FSM HANDLER:
  - No requests; new sources still latch.
  - eret on update: MIE<=MPIE, MPIE<=1, go to IDLE. Still-pending sources re-request from IDLE.
  - x_exception_taken_i is ignored.
- x_exception_vector_o = mtvec + (VECTORED && cause_q[31] ? 4*cause_q[4:0] : 0), taken from the registered cause_q.
- x_exception_pc_o = mepc. mepc is also writable via CSR.

Decomposition:
- Add cause codes, mip bit indices, CSR_ID_MTVEC and the mstatus bit positions to urv_defs.v.
- One sub-module, urv_irq_prio_enc: parameterised fixed-priority encoder, (4+1+N_IRQ)-bit request vector in, valid + 32-bit cause out.

Test Plan:
- Invalid insn pulse at cycle 10, ack at 13 with PC 0x100 -> x_exception_o high 11..13; mepc=0x100; mcause=0x2; vector=mtvec=0x8; MIE=0.
- N_IRQ=4, IRQ_EDGE=4'b0100, mtvec=0x200, mie=0x40000, MIE=1; pulse irq2 for 1 cycle -> mcause=0x80000012; vector=0x248; mip[18] clear after ack.
- Level irq1 held, mie bit17 set, MIE=0 -> no request; set MIE -> request in 2 cycles; irq1 dropped before ack -> x_exception_o deasserts, state IDLE.
- Breakpoint and timer in the same cycle -> mcause=3 first; after eret, timer trap with mcause=0x80000007; MIE restored to 1 on each eret.
- Async reset asserted in REQ -> all outputs at reset values immediately; mtvec=RESET_VECTOR.
- Take coincident with stall -> ignored until stall drops; mepc captured from the unstalled cycle's PC.
